cache_dir_ctrl: RTL and testbench

Parametrised set-associative cache directory controller: per-set tag store, per-way MESI state and per-set tree pseudo-LRU. It accepts one trace command per handshake, performs lookup, victim selection, MESI transition and PLRU update, and reports hit/miss, way, bus operation and writeback need. It is the synthesizable successor to the fixed 8-way/16K-set simulator data structures, and shares their command and MESI encodings. It adds configurable geometry, snoop handling, a clear sweep and hit/miss counters.

---
 rtl/cache_dir_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_cache_dir_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cache_dir_ctrl.sv
// Set-associative cache directory: per-set tags, per-way MESI, tree PLRU.
// One command in flight; INIT/CLEAR sweep one set per cycle.
module cache_dir_ctrl #(
  parameter  int WAYS       = 8,
  parameter  int SETS       = 16384,
  parameter  int ADDR_W     = 32,
  parameter  int LINE_BYTES = 64,
  localparam int OFF_W      = $clog2(LINE_BYTES),
  localparam int IDX_W      = $clog2(SETS),
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
  localparam int WAY_W      = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        snoop_in,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic [1:0]        rsp_mesi_old,
  output logic [1:0]        rsp_mesi_new,
  output logic [2:0]        rsp_busop,
  output logic              rsp_evict,
  output logic [TAG_W-1:0]  rsp_victim_tag,
  output logic              rsp_err,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam logic [3:0] CMD_READ = 4'd0, CMD_WRITE = 4'd1, CMD_IFETCH = 4'd2,
                         CMD_INVAL = 4'd3, CMD_DATA = 4'd4, CMD_CLR = 4'd8;
  localparam logic [1:0] MESI_I = 2'd0, MESI_E = 2'd1, MESI_S = 2'd2, MESI_M = 2'd3;
  localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2,
                         BUS_INV = 3'd3, BUS_RWIM = 3'd4;
  localparam logic [1:0] SNP_NOHIT = 2'd0;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_CLEAR, S_RESP} state_t;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic [1:0]       mesi_old;
    logic [1:0]       mesi_new;
    logic [2:0]       busop;
    logic             evict;
    logic [TAG_W-1:0] vtag;
    logic             err;
  } rsp_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [3:0]       cmd_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_in_q;
  logic [1:0]       snoop_q;
  rsp_t             rsp_q, rsp_d;
  logic [31:0]      hit_cnt_q, miss_cnt_q;
  logic             mesi_we_q, mesi_we_d, tag_we_q, tag_we_d, plru_we_q, plru_we_d;
  logic             cnt_hit_q, cnt_hit_d, cnt_miss_q, cnt_miss_d;
  logic [WAYS-1:0]  plru_new_q, plru_new_d;

  // PLRU rows carry one spare MSB so node indices fit in WAY_W bits; it stays 0.
  logic [WAYS-1:0][TAG_W-1:0] tag_q  [SETS];
  logic [WAYS-1:0][1:0]       mesi_q [SETS];
  logic [WAYS-1:0]            plru_q [SETS];

  logic                       unused_off;
  assign unused_off = ^req_addr[OFF_W-1:0];

  logic [WAYS-1:0][TAG_W-1:0] set_tag;
  logic [WAYS-1:0][1:0]       set_mesi;
  logic [WAYS-1:0]            set_plru;
  logic [WAYS-1:0]            hit_vec, inv_vec;
  logic [WAY_W-1:0]           hit_way, inv_way, plru_way, victim, sel_way;
  logic                       lk_hit;
  logic [1:0]                 old_st;

  assign set_tag  = tag_q[idx_q];
  assign set_mesi = mesi_q[idx_q];
  assign set_plru = plru_q[idx_q];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign inv_vec[w] = (set_mesi[w] == MESI_I);
    assign hit_vec[w] = !inv_vec[w] && (set_tag[w] == tag_in_q);
  end

  // Point every node on w's root-to-leaf path away from w.
  function automatic logic [WAYS-1:0] touch(input logic [WAYS-1:0] t, input logic [WAY_W-1:0] w);
    logic [WAY_W-1:0] nd, ww;
    logic             b;
    touch = t;
    nd    = '0;
    ww    = w;
    for (int l = 0; l < WAY_W; l++) begin
      b         = ww[WAY_W-1];
      ww        = ww << 1;
      touch[nd] = ~b;
      nd        = WAY_W'({nd, 1'b1}) + WAY_W'(b);
    end
  endfunction

  always_comb begin
    logic [WAY_W-1:0] nd;
    logic             b;
    hit_way  = '0;
    inv_way  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (inv_vec[w]) inv_way = WAY_W'(w);
    end
    nd       = '0;
    plru_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b        = set_plru[nd];
      plru_way = (plru_way << 1) | WAY_W'(b);
      nd       = WAY_W'({nd, 1'b1}) + WAY_W'(b);
    end
    lk_hit  = |hit_vec;
    victim  = (|inv_vec) ? inv_way : plru_way;
    sel_way = lk_hit ? hit_way : victim;
    old_st  = set_mesi[sel_way];
  end

  always_comb begin
    rsp_d          = '0;
    rsp_d.hit      = lk_hit;
    rsp_d.way      = sel_way;
    rsp_d.mesi_old = old_st;
    rsp_d.mesi_new = old_st;
    mesi_we_d      = 1'b0;
    tag_we_d       = 1'b0;
    plru_we_d      = 1'b0;
    cnt_hit_d      = 1'b0;
    cnt_miss_d     = 1'b0;
    plru_new_d     = set_plru;
    case (cmd_q)
      CMD_READ, CMD_IFETCH, CMD_WRITE: begin
        plru_we_d  = 1'b1;
        plru_new_d = touch(set_plru, sel_way);
        cnt_hit_d  = lk_hit;
        cnt_miss_d = !lk_hit;
        if (!lk_hit) begin
          mesi_we_d   = 1'b1;
          tag_we_d    = 1'b1;
          rsp_d.evict = (old_st == MESI_M);
          rsp_d.vtag  = (old_st == MESI_M) ? set_tag[sel_way] : '0;
        end
        if (cmd_q == CMD_WRITE) begin
          mesi_we_d      = 1'b1;
          rsp_d.mesi_new = MESI_M;
          rsp_d.busop    = !lk_hit ? BUS_RWIM : (old_st == MESI_S) ? BUS_INV : BUS_NONE;
        end else if (!lk_hit) begin
          rsp_d.busop    = BUS_READ;
          rsp_d.mesi_new = (snoop_q == SNP_NOHIT) ? MESI_E : MESI_S;
        end
      end
      CMD_INVAL: if (lk_hit) begin
        mesi_we_d      = 1'b1;
        rsp_d.mesi_new = MESI_I;
        if (old_st == MESI_M) begin
          rsp_d.evict = 1'b1;
          rsp_d.busop = BUS_WRITE;
          rsp_d.vtag  = tag_in_q;
        end
      end
      CMD_DATA: if (lk_hit && old_st != MESI_S) begin
        mesi_we_d      = 1'b1;
        rsp_d.mesi_new = MESI_S;
        if (old_st == MESI_M) begin
          rsp_d.evict = 1'b1;
          rsp_d.busop = BUS_WRITE;
          rsp_d.vtag  = tag_in_q;
        end
      end
      default: begin
        rsp_d     = '0;
        rsp_d.err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    sweep_d = '0;
    case (state_q)
      S_INIT, S_CLEAR: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(SETS-1)) state_d = (state_q == S_INIT) ? S_IDLE : S_RESP;
      end
      S_IDLE:   if (req_valid) state_d = (req_cmd == CMD_CLR) ? S_CLEAR : S_LOOKUP;
      S_LOOKUP: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      cmd_q      <= '0;
      idx_q      <= '0;
      tag_in_q   <= '0;
      snoop_q    <= '0;
      rsp_q      <= '0;
      mesi_we_q  <= 1'b0;
      tag_we_q   <= 1'b0;
      plru_we_q  <= 1'b0;
      cnt_hit_q  <= 1'b0;
      cnt_miss_q <= 1'b0;
      plru_new_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      if (state_q == S_IDLE && req_valid) begin
        cmd_q    <= req_cmd;
        idx_q    <= req_addr[IDX_W+OFF_W-1:OFF_W];
        tag_in_q <= req_addr[ADDR_W-1:IDX_W+OFF_W];
        snoop_q  <= snoop_in;
      end
      if (state_q == S_LOOKUP) begin
        rsp_q      <= rsp_d;
        mesi_we_q  <= mesi_we_d;
        tag_we_q   <= tag_we_d;
        plru_we_q  <= plru_we_d;
        cnt_hit_q  <= cnt_hit_d;
        cnt_miss_q <= cnt_miss_d;
        plru_new_q <= plru_new_d;
      end else if (state_q == S_CLEAR && state_d == S_RESP) begin
        rsp_q      <= '0;
        mesi_we_q  <= 1'b0;
        tag_we_q   <= 1'b0;
        plru_we_q  <= 1'b0;
        cnt_hit_q  <= 1'b0;
        cnt_miss_q <= 1'b0;
      end
      if (state_q == S_IDLE && req_valid && req_cmd == CMD_CLR) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else if (state_q == S_RESP) begin
        if (cnt_hit_q && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
        if (cnt_miss_q && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  // Directory arrays need no reset: the INIT sweep invalidates every set.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT || state_q == S_CLEAR) begin
      mesi_q[sweep_q] <= '0;
      plru_q[sweep_q] <= '0;
    end else if (state_q == S_RESP) begin
      if (plru_we_q) plru_q[idx_q]               <= plru_new_q;
      if (mesi_we_q) mesi_q[idx_q][rsp_q.way]    <= rsp_q.mesi_new;
      if (tag_we_q)  tag_q[idx_q][rsp_q.way]     <= tag_in_q;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_hit        = rsp_q.hit;
  assign rsp_way        = rsp_q.way;
  assign rsp_mesi_old   = rsp_q.mesi_old;
  assign rsp_mesi_new   = rsp_q.mesi_new;
  assign rsp_busop      = rsp_q.busop;
  assign rsp_evict      = rsp_q.evict;
  assign rsp_victim_tag = rsp_q.vtag;
  assign rsp_err        = rsp_q.err;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_cache_dir_ctrl.sv
// Directed bench for cache_dir_ctrl at 8 ways x 16 sets, 64B lines.
module tb_cache_dir_ctrl;
  localparam int WAYS = 8, SETS = 16, ADDR_W = 32, LINE_BYTES = 64;
  localparam int WAY_W = 3, TAG_W = 22;
  localparam logic [3:0] RD = 4'd0, WR = 4'd1, IF = 4'd2, INV = 4'd3, DRQ = 4'd4, CLR = 4'd8;
  localparam logic [31:0] STEP = 32'h0010_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid, req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        snoop_in;
  logic              rsp_valid, rsp_hit, rsp_evict, rsp_err;
  logic [WAY_W-1:0]  rsp_way;
  logic [1:0]        rsp_mesi_old, rsp_mesi_new;
  logic [2:0]        rsp_busop;
  logic [TAG_W-1:0]  rsp_victim_tag;
  logic [31:0]       hit_cnt, miss_cnt;

  int n_chk = 0, n_err = 0;
  int e_hit = 0, e_miss = 0;

  cache_dir_ctrl #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .snoop_in(snoop_in),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_mesi_old(rsp_mesi_old), .rsp_mesi_new(rsp_mesi_new), .rsp_busop(rsp_busop),
    .rsp_evict(rsp_evict), .rsp_victim_tag(rsp_victim_tag), .rsp_err(rsp_err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", t, act, exp);
    end
  endtask

  task automatic req(input logic [3:0] cmd, input logic [31:0] addr, input logic [1:0] snp,
                     input logic e_h, input logic [2:0] e_way, input logic [1:0] e_new,
                     input logic [2:0] e_bus, input logic e_ev);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("rdy@%h", addr), req_ready, 1);
    req_cmd = cmd; req_addr = addr; snoop_in = snp; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk($sformatf("lat@%h", addr), n, 2);
    chk($sformatf("hit@%h", addr), rsp_hit, e_h);
    chk($sformatf("way@%h", addr), rsp_way, e_way);
    chk($sformatf("new@%h", addr), rsp_mesi_new, e_new);
    chk($sformatf("bus@%h", addr), rsp_busop, e_bus);
    chk($sformatf("evict@%h", addr), rsp_evict, e_ev);
    if (cmd == RD || cmd == WR || cmd == IF) begin
      if (e_h) e_hit++; else e_miss++;
    end
  endtask

  task automatic chk_cnt(input string t);
    @(negedge clk);
    chk({t, "_hit"}, hit_cnt, e_hit);
    chk({t, "_miss"}, miss_cnt, e_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_cmd = '0; req_addr = '0; snoop_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", req_ready, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_hit", rsp_hit, 0);
    chk("rst_way", rsp_way, 0);
    chk("rst_bus", rsp_busop, 0);
    chk("rst_ev", rsp_evict, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_hc", hit_cnt, 0);
    chk("rst_mc", miss_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= SETS; i++) begin
      @(posedge clk); #1;
      chk("init_rdy", req_ready, i == SETS);
    end

    // First fill then hit on the same line
    req(RD, 32'h40, 2'd0, 0, 0, 2'd1, 3'd1, 0);
    req(RD, 32'h40, 2'd0, 1, 0, 2'd1, 3'd0, 0);
    chk_cnt("cnt_a");

    // Fill set 1; PLRU ends pointing at way 0
    for (int t = 0; t < 8; t++)
      req(RD, 32'h40 + t * STEP, 2'd0, t == 0, 3'(t), 2'd1, (t == 0) ? 3'd0 : 3'd1, 0);
    req(RD, 32'h40 + 8 * STEP, 2'd0, 0, 0, 2'd1, 3'd1, 0);

    // Write hits on E and on S lines, then evict the M line
    req(WR, 32'h40 + STEP, 2'd0, 1, 1, 2'd3, 3'd0, 0);
    req(RD, 32'h0123_4480, 2'd1, 0, 0, 2'd2, 3'd1, 0);
    req(WR, 32'h0123_4480, 2'd0, 1, 0, 2'd3, 3'd3, 0);
    for (int t = 1; t < 8; t++)
      req(RD, 32'h80 + t * STEP, 2'd0, 0, 3'(t), 2'd1, 3'd1, 0);
    req(RD, 32'h80 + 8 * STEP, 2'd0, 0, 0, 2'd1, 3'd1, 1);
    chk("vtag", rsp_victim_tag, 22'h48D1);
    chk("vold", rsp_mesi_old, 2'd3);
    chk_cnt("cnt_b");

    // Snoops: M -> S with writeback, S -> I, then a miss; counters untouched
    req(DRQ, 32'h40 + STEP, 2'd0, 1, 1, 2'd2, 3'd2, 1);
    chk("drq_vtag", rsp_victim_tag, 22'd1024);
    req(INV, 32'h40 + STEP, 2'd0, 1, 1, 2'd0, 3'd0, 0);
    req(INV, 32'h40 + 9 * STEP, 2'd0, 0, 1, 2'd0, 3'd0, 0);
    chk_cnt("cnt_snp");
    req(RD, 32'h40 + STEP, 2'd0, 0, 1, 2'd1, 3'd1, 0);

    // Clear sweep
    chk_cnt("cnt_pre_clr");
    chk("clr_start", req_ready, 1);
    req_cmd = CLR; req_addr = '0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    e_hit = 0; e_miss = 0;
    for (int i = 1; i <= SETS + 2; i++) begin
      @(negedge clk);
      chk("clr_rdy", req_ready, i == SETS + 2);
      chk("clr_vld", rsp_valid, i == SETS + 1);
      if (i == 1) chk("clr_cnt", hit_cnt + miss_cnt, 0);
      if (i == SETS + 1) chk("clr_err", rsp_err, 0);
    end
    req(RD, 32'h40, 2'd0, 0, 0, 2'd1, 3'd1, 0);
    chk_cnt("cnt_clr");

    // Unsupported command leaves state alone
    req(4'd5, 32'h40, 2'd0, 0, 0, 2'd0, 3'd0, 0);
    chk("err5", rsp_err, 1);
    req(RD, 32'h40, 2'd0, 1, 0, 2'd1, 3'd0, 0);
    chk("err_clr", rsp_err, 0);
    req(IF, 32'hC0, 2'd2, 0, 0, 2'd2, 3'd1, 0);
    chk_cnt("cnt_err");

    // Reset during LOOKUP aborts the request and restarts INIT
    req_cmd = RD; req_addr = 32'h40; snoop_in = '0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("ar_rdy", req_ready, 0);
    chk("ar_vld", rsp_valid, 0);
    chk("ar_bus", rsp_busop, 0);
    chk("ar_cnt", hit_cnt + miss_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= SETS; i++) begin
      @(posedge clk); #1;
      chk("ar_init_rdy", req_ready, i == SETS);
      chk("ar_init_vld", rsp_valid, 0);
    end
    e_hit = 0; e_miss = 0;
    req(RD, 32'h40, 2'd0, 0, 0, 2'd1, 3'd1, 0);
    chk_cnt("cnt_ar");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
